// File: rtl/instr_encoder_if.sv
// Bundle-in / memory-write-out signal group for the instruction encoder.
// The slave side is the encoder; the master side is whoever feeds fields and sinks words.
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);

   logic                  clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            fmt;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [31:0]           imm;
   logic                  mem_we;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  range_err;
   logic                  wrap;

   modport slave (
      input  clear,
      input  in_valid,
      output in_ready,
      input  fmt,
      input  opcode,
      input  funct3,
      input  funct7,
      input  rd,
      input  rs1,
      input  rs2,
      input  imm,
      output mem_we,
      input  mem_ready,
      output mem_addr,
      output mem_wdata,
      output range_err,
      output wrap
   );

   modport master (
      output clear,
      output in_valid,
      input  in_ready,
      output fmt,
      output opcode,
      output funct3,
      output funct7,
      output rd,
      output rs1,
      output rs2,
      output imm,
      input  mem_we,
      output mem_ready,
      input  mem_addr,
      input  mem_wdata,
      input  range_err,
      input  wrap
   );

endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V I/S/B/R fields into instruction words and streams them to memory
// at an auto-incrementing word address through a one-entry output register.
module instr_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_S = 2'b01,
      FMT_B = 2'b10,
      FMT_R = 2'b11
   } fmt_e;

   fmt_e                  fmtSel;
   logic [31:0]           encWord;
   logic                  immLegal;
   logic                  accept;
   logic                  handoff;
   logic [ADDR_WIDTH-1:0] countInc;

   logic                  memWe_q,    memWe_d;
   logic [31:0]           memWdata_q, memWdata_d;
   logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
   logic [ADDR_WIDTH-1:0] count_q,    count_d;
   logic                  rangeErr_q, rangeErr_d;
   logic                  wrap_q,     wrap_d;

   assign fmtSel   = fmt_e'(bus.fmt);
   assign handoff  = memWe_q && bus.mem_ready;
   assign accept   = bus.in_valid && bus.in_ready;
   assign countInc = count_q + 1'b1;

   // The output slot frees up in the same cycle it is handed off, giving one word per cycle.
   assign bus.in_ready  = !bus.clear && (!memWe_q || bus.mem_ready);
   assign bus.mem_we    = memWe_q;
   assign bus.mem_wdata = memWdata_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.range_err = rangeErr_q;
   assign bus.wrap      = wrap_q;

   // Field packing; B drops imm[0] since branch targets are always even.
   always_comb begin
      encWord = '0;
      case (fmtSel)
         FMT_I: encWord = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_S: encWord = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:0], bus.opcode};
         FMT_B: encWord = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], bus.opcode};
         FMT_R: encWord = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         default: encWord = '0;
      endcase
   end

   // An immediate fits when every bit above the field's sign bit copies that sign bit.
   always_comb begin
      immLegal = 1'b0;
      case (fmtSel)
         FMT_I, FMT_S: immLegal = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
         FMT_B:        immLegal = ((&bus.imm[31:12]) || !(|bus.imm[31:12])) && !bus.imm[0];
         FMT_R:        immLegal = 1'b1;
         default:      immLegal = 1'b0;
      endcase
   end

   // Next-state: clear wins over everything, then handoff retires the word, then accept refills.
   always_comb begin
      memWe_d    = memWe_q;
      memWdata_d = memWdata_q;
      memAddr_d  = memAddr_q;
      count_d    = count_q;
      rangeErr_d = rangeErr_q;
      wrap_d     = wrap_q;
      if (bus.clear) begin
         memWe_d    = 1'b0;
         memAddr_d  = '0;
         count_d    = '0;
         rangeErr_d = 1'b0;
         wrap_d     = 1'b0;
      end else begin
         if (handoff) begin
            memWe_d = 1'b0;
            count_d = countInc;
            if (&count_q) begin
               wrap_d = 1'b1;
            end
         end
         if (accept) begin
            if (immLegal) begin
               memWe_d    = 1'b1;
               memWdata_d = encWord;
               memAddr_d  = count_d;
            end else begin
               rangeErr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memWe_q    <= 1'b0;
         memWdata_q <= '0;
         memAddr_q  <= '0;
         count_q    <= '0;
         rangeErr_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         memWe_q    <= memWe_d;
         memWdata_q <= memWdata_d;
         memAddr_q  <= memAddr_d;
         count_q    <= count_d;
         rangeErr_q <= rangeErr_d;
         wrap_q     <= wrap_d;
      end
   end

   // A stalled word must not change under the memory's feet.
   holdWhileStalled: assert property (
      @(posedge clk) disable iff (reset)
      (memWe_q && !bus.mem_ready && !bus.clear) |=> ($stable(memWdata_q) && $stable(memAddr_q) && memWe_q)
   );

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder against an arithmetic reference model
// with an expected-write queue, address counter and sticky flags.
module tb_instr_encoder;

   localparam int AW = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   word;
      logic [1:0]    fmt;
      int            imm;
   } entry_t;

   logic clk;
   logic reset;

   instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

   instr_encoder #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int     checkCount = 0;
   int     passCount  = 0;
   int     readyMode  = 0;
   bit     monitorOn  = 0;

   entry_t        expQ[$];
   int            expCnt   = 0;
   bit            expRerr  = 0;
   bit            expWrap  = 0;

   int bounds[12] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, -4095, 0, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit isLegal(input logic [1:0] f, input int v);
      case (f)
         2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
         2'd2:       return (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] refEncode(input logic [1:0] f, input int v,
                                            input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2);
      logic [31:0] u;
      logic [31:0] base;
      u    = v;
      base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
      case (f)
         2'd0:    return base | ((u & 32'hFFF) << 20) | (32'(d) << 7);
         2'd1:    return base | (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | ((u & 32'h1F) << 7);
         2'd2:    return base | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                              | (32'(s2) << 20) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
         default: return base | (32'(f7) << 25) | (32'(s2) << 20) | (32'(d) << 7);
      endcase
   endfunction

   // The core's immediate extender, used to prove the round trip.
   function automatic int extImm(input logic [1:0] f, input logic [31:0] w);
      logic signed [11:0] t12;
      logic signed [12:0] t13;
      case (f)
         2'd0:    begin t12 = w[31:20];                               return int'(t12); end
         2'd1:    begin t12 = {w[31:25], w[11:7]};                    return int'(t12); end
         default: begin t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'(t13); end
      endcase
   endfunction

   // Reference model: checks the outputs that hold before each rising edge, then advances.
   always @(negedge clk) begin
      if (reset) begin
         expQ.delete();
         expCnt  = 0;
         expRerr = 0;
         expWrap = 0;
      end else if (monitorOn) begin
         bit expReady;
         bit hand;
         expReady = !bus.clear && (expQ.size() == 0 || bus.mem_ready);
         checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
         checkOutput("mem_we", 32'(bus.mem_we), 32'(expQ.size() != 0));
         checkOutput("range_err", 32'(bus.range_err), 32'(expRerr));
         checkOutput("wrap", 32'(bus.wrap), 32'(expWrap));
         if (expQ.size() != 0) begin
            checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expQ[0].addr));
            checkOutput("mem_wdata", bus.mem_wdata, expQ[0].word);
            if (expQ[0].fmt != 2'd3) begin
               checkOutput("roundtrip", 32'(extImm(expQ[0].fmt, bus.mem_wdata)), 32'(expQ[0].imm));
            end
         end
         hand = (expQ.size() != 0) && bus.mem_ready;
         if (bus.clear) begin
            expQ.delete();
            expCnt  = 0;
            expRerr = 0;
            expWrap = 0;
         end else begin
            if (hand) begin
               void'(expQ.pop_front());
               if (expCnt == (1 << AW) - 1) expWrap = 1;
               expCnt = (expCnt + 1) % (1 << AW);
            end
            if (bus.in_valid && expReady) begin
               int v;
               v = int'(bus.imm);
               if (isLegal(bus.fmt, v)) begin
                  entry_t e;
                  e.addr = AW'(expCnt);
                  e.word = refEncode(bus.fmt, v, bus.opcode, bus.funct3, bus.funct7,
                                     bus.rd, bus.rs1, bus.rs2);
                  e.fmt  = bus.fmt;
                  e.imm  = v;
                  expQ.push_back(e);
               end else begin
                  expRerr = 1;
               end
            end
         end
      end
   end

   // Memory-side readiness: always ready, a 1,0,0,1 pattern, or random.
   initial begin
      int patIdx;
      patIdx = 0;
      bus.mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       bus.mem_ready = 1'b1;
            1:       begin bus.mem_ready = (patIdx % 4 == 0) || (patIdx % 4 == 3); patIdx++; end
            default: bus.mem_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input int v);
      bit taken;
      bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
      bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = v;
      bus.in_valid = 1'b1;
      taken = 0;
      for (int i = 0; i < 64 && !taken; i++) begin
         @(negedge clk);
         taken = bus.in_ready;
         cycle();
      end
      bus.in_valid = 1'b0;
      if (!taken) checkOutput("acceptTimeout", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic sendRandomLegal();
      applyStimulus(2'd3, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 0);
   endtask

   task automatic pulseClear();
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && expQ.size() != 0; i++) cycle();
      if (expQ.size() != 0) checkOutput("drainTimeout", 32'(bus.mem_we), 32'd0);
   endtask

   function automatic int pickImm();
      case ($urandom_range(0, 4))
         0:       return int'($urandom_range(0, 4095)) - 2048;
         1:       return bounds[$urandom_range(0, 11)];
         2:       return int'($urandom_range(0, 8191)) - 4096;
         3:       return int'($urandom_range(0, 4095)) * 2 - 4096;
         default: return int'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.funct3 = '0;
      bus.funct7 = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
      checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("rst_rerr", 32'(bus.range_err), 32'd0);
      checkOutput("rst_wrap", 32'(bus.wrap), 32'd0);
      reset = 1'b0;
      monitorOn = 1'b1;
      cycle();

      // I-type addi x1,x2,-1
      applyStimulus(2'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, -1);
      checkOutput("i_word", bus.mem_wdata, 32'hFFF10093);
      checkOutput("i_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("i_we", 32'(bus.mem_we), 32'd1);
      cycle();
      checkOutput("i_idle_we", 32'(bus.mem_we), 32'd0);

      // S and B from a cleared counter
      pulseClear();
      applyStimulus(2'd1, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, -4);
      checkOutput("s_word", bus.mem_wdata, 32'hFE512E23);
      applyStimulus(2'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -8);
      checkOutput("b_word", bus.mem_wdata, 32'hFE208CE3);
      checkOutput("b_addr", 32'(bus.mem_addr), 32'd1);
      drain();

      // Range errors
      pulseClear();
      applyStimulus(2'd0, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 2048);
      checkOutput("rng_i_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rng_i_err", 32'(bus.range_err), 32'd1);
      applyStimulus(2'd2, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 3);
      checkOutput("rng_b_odd_we", 32'(bus.mem_we), 32'd0);
      applyStimulus(2'd2, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 4094);
      checkOutput("rng_b_max_we", 32'(bus.mem_we), 32'd1);
      checkOutput("rng_b_max_addr", 32'(bus.mem_addr), 32'd0);
      sendRandomLegal();
      checkOutput("rng_next_addr", 32'(bus.mem_addr), 32'd1);
      drain();

      // Backpressure with a 1,0,0,1 ready pattern
      pulseClear();
      readyMode = 1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'd0, 7'b0000011, 3'($urandom), 7'd0, 5'($urandom), 5'($urandom),
                       5'd0, pickImm() % 2048);
      end
      drain();
      readyMode = 0;
      checkOutput("bp_count", 32'(expCnt), 32'd4);

      // Wrap after 2^AW handoffs
      pulseClear();
      for (int i = 0; i < (1 << AW); i++) sendRandomLegal();
      checkOutput("wrap_before", 32'(bus.wrap), 32'd0);
      sendRandomLegal();
      checkOutput("wrap_after", 32'(bus.wrap), 32'd1);
      checkOutput("wrap_addr", 32'(bus.mem_addr), 32'd0);

      // Clear overriding a live handoff
      pulseClear();
      sendRandomLegal();
      pulseClear();
      checkOutput("clr_we", 32'(bus.mem_we), 32'd0);
      sendRandomLegal();
      checkOutput("clr_addr", 32'(bus.mem_addr), 32'd0);

      // Asynchronous reset mid-cycle with a word pending
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_we", 32'(bus.mem_we), 32'd0);
      checkOutput("arst_wdata", bus.mem_wdata, 32'd0);
      checkOutput("arst_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle();

      // Randomised traffic with random readiness and occasional clears
      readyMode = 2;
      for (int i = 0; i < 600; i++) begin
         bus.fmt      = 2'($urandom);
         bus.opcode   = 7'($urandom);
         bus.funct3   = 3'($urandom);
         bus.funct7   = 7'($urandom);
         bus.rd       = 5'($urandom);
         bus.rs1      = 5'($urandom);
         bus.rs2      = 5'($urandom);
         bus.imm      = pickImm();
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.clear    = ($urandom_range(0, 39) == 0);
         cycle();
      end
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      readyMode    = 0;
      cycle();
      drain();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs decoded RISC-V fields plus a sign-extended 32-bit immediate into a 32-bit instruction word for I/S/B/R formats. It then streams the word into instruction memory at an auto-incrementing word address. It is the inverse of the core's immediate extender: it is used by the program loader and self-test paths to build instruction words. One-entry registered output stage with valid/ready handshakes on both sides.

Parameters:
ADDR_WIDTH, 8, width of the word address counter; the counter wraps at 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush: address to 0, pending word dropped, flags cleared.
in_valid  input  1  field bundle valid.
in_ready  output  1  bundle accepted when in_valid && in_ready.
fmt  input  2  format code: 00 I, 01 S, 10 B, 11 R.
opcode  input  7  instr[6:0].
funct3  input  3  instr[14:12].
funct7  input  7  instr[31:25]; R only.
rd  input  5  instr[11:7]; I and R only.
rs1  input  5  instr[19:15].
rs2  input  5  instr[24:20]; S, B and R only.
imm  input  32  two's-complement immediate value; ignored for R.
mem_we  output  1  write word valid.
mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
mem_addr  output  ADDR_WIDTH  word address of mem_wdata.
mem_wdata  output  32  encoded instruction.
range_err  output  1  sticky: an out-of-range immediate was dropped.
wrap  output  1  sticky: address counter wrapped.

Behaviour:
- Reset values, with reset asynchronous: mem_we=0, mem_wdata=0, mem_addr=0, range_err=0, wrap=0. Output register is empty.
- Ready rule: in_ready = !clear && (!mem_we || mem_ready). It is combinational and has no dependence on in_valid.
- Encoding:
  - I = {imm[11:0], rs1, funct3, rd, opcode}.
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - R = {funct7, rs2, rs1, funct3, rd, opcode}.
- Range check, applied only on accept:
  - I and S: imm must lie in -2048..2047.
  - B: imm must lie in -4096..4094 and imm[0] must be 0.
  - R: always legal.
- Legal accept: at the accepting edge, mem_wdata takes the encoded word, mem_we=1, and mem_addr takes the current counter value. Latency is 1 cycle from accept to mem_we.
- Illegal accept: the bundle is consumed and no word is produced. range_err is set. mem_we is cleared if the previous word was handed off on that edge. The counter is unchanged.
- Handoff: on mem_we && mem_ready, the counter increments mod 2^ADDR_WIDTH. If it goes from all-ones to 0, wrap is set.
- Simultaneous handoff and legal accept: the next word loads in the same edge. mem_we stays 1 and mem_addr equals the incremented counter. Back-to-back throughput is 1 word per cycle.
- Backpressure: while mem_we && !mem_ready, mem_wdata and mem_addr hold stable and in_ready=0.
- Addressing: mem_addr always equals the counter while mem_we=1. The counter value is the number of completed writes mod 2^ADDR_WIDTH since the last clear or reset.
- clear: at the next edge, mem_we=0, counter=0, range_err=0, wrap=0. No input is accepted that cycle. It overrides a handoff in the same cycle: that handoff does not increment the counter and does not set wrap.
- Reset mid-transfer: the pending word is lost and there is no partial write.
- Round-trip invariant: for every legal input, the core immediate extender applied to mem_wdata for the same format returns imm exactly.

Test Plan:
1. I-type: fmt=00, opcode=0010011, rd=1, rs1=2, funct3=0, imm=-1, with mem_ready=1 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0xFFF10093. The next cycle, with no input, mem_we=0.
2. S and B: S-type (sw), fmt=01, opcode=0100011, funct3=010, rs1=2, rs2=5, imm=-4 -> mem_wdata=0xFE512E23. B-type (beq), fmt=10, opcode=1100011, funct3=0, rs1=1, rs2=2, imm=-8 -> mem_wdata=0xFE208CE3 at mem_addr=1.
3. Range errors: I imm=2048 -> no mem_we and range_err=1. B imm=3 -> dropped. B imm=4094 -> written. The counter advances by exactly 1 across the three inputs.
4. Backpressure: 4 back-to-back legal inputs while mem_ready toggles 1,0,0,1,... -> each word is stable while stalled. Addresses are 0,1,2,3 in order with no loss or duplication.
5. Wrap: with ADDR_WIDTH=2, send 5 legal words -> addresses are 0,1,2,3,0 and wrap=1 after the 4th handoff.
6. Control: clear asserted while mem_we=1 and mem_ready=1 -> next cycle mem_we=0 and the counter is 0. Async reset pulsed mid-cycle -> outputs are 0 immediately, without waiting for a clock edge.
